// File: rtl/inference_pkg.sv
// Shared types and constants for the inference datapath: FP16 width,
// default vocabulary sizing, argmax FSM states and the canonical quiet NaN.
package inference_pkg;

    localparam int FP16_W         = 16;
    localparam int VOCAB_SIZE_DEF = 128;
    localparam int TOKEN_W_DEF    = 7;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ARGMAX_IDLE,
        ARGMAX_COLLECT,
        ARGMAX_DONE
    } argmax_state_t;

    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

endpackage

// File: rtl/fp16_order_key.sv
// Maps an FP16 value to an unsigned key whose integer order matches the
// numeric order of the floats (-0 folded onto +0), and flags NaNs.
module fp16_order_key
    import inference_pkg::*;
(
    input  logic [FP16_W-1:0] value,
    output logic [FP16_W-1:0] key,
    output logic              is_nan
);

    logic [FP16_W-1:0] norm;

    always_comb begin
        norm   = (value == 16'h8000) ? '0 : value;
        // Negatives invert so larger magnitude sorts lower; positives sit above all negatives.
        key    = norm[FP16_W-1] ? ~norm : (norm ^ 16'h8000);
        is_nan = fp16_is_nan(value);
    end

endmodule

// File: rtl/logit_argmax.sv
// Streaming argmax over one generation step of FP16 logits.
// Optional build macro ARGMAX_NAN_SKIP_EN: NaN logits are counted but never win.
module logit_argmax
    import inference_pkg::*;
#(
    parameter int VOCAB_SIZE = VOCAB_SIZE_DEF,
    parameter int TOKEN_W    = TOKEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               logit_valid,
    input  logic [FP16_W-1:0]  logit_data,
    input  logic               logit_last,
    output logic               busy,
    output logic               token_valid,
    output logic [TOKEN_W-1:0] token,
    output logic [FP16_W-1:0]  max_logit,
    output logic               length_error,
    output logic               nan_seen
);

`ifdef ARGMAX_NAN_SKIP_EN
    localparam bit NAN_SKIP = 1'b1;
`else
    localparam bit NAN_SKIP = 1'b0;
`endif

    localparam logic [TOKEN_W-1:0] LAST_IDX = TOKEN_W'(VOCAB_SIZE - 1);

    argmax_state_t      state;
    logic [TOKEN_W-1:0] idx;
    logic [TOKEN_W-1:0] best_index;
    logic [FP16_W-1:0]  best_key;
    logic [FP16_W-1:0]  best_value;
    logic               best_vld;

    logic [FP16_W-1:0]  key;
    logic               is_nan;

    logic               accept;
    logic               eligible;
    logic               better;
    logic               final_beat;
    logic [TOKEN_W-1:0] nxt_index;
    logic [FP16_W-1:0]  nxt_value;
    logic               nxt_vld;

    fp16_order_key u_key (
        .value  (logit_data),
        .key    (key),
        .is_nan (is_nan)
    );

    // Fold the current beat into the running best so the final beat is
    // reported on the same edge it is accepted.
    always_comb begin
        accept     = (state == ARGMAX_COLLECT) && logit_valid;
        eligible   = !(NAN_SKIP && is_nan);
        better     = accept && eligible && (!best_vld || (key > best_key));
        final_beat = accept && (logit_last || (idx == LAST_IDX));
        nxt_index  = better ? idx : best_index;
        nxt_value  = better ? logit_data : best_value;
        nxt_vld    = best_vld || better;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARGMAX_IDLE;
            busy         <= 1'b0;
            token_valid  <= 1'b0;
            length_error <= 1'b0;
            nan_seen     <= 1'b0;
            token        <= '0;
            max_logit    <= '0;
            idx          <= '0;
            best_index   <= '0;
            best_vld     <= 1'b0;
        end else begin
            case (state)
                ARGMAX_IDLE: begin
                    token_valid <= 1'b0;
                    if (start) begin
                        state        <= ARGMAX_COLLECT;
                        busy         <= 1'b1;
                        idx          <= '0;
                        best_index   <= '0;
                        best_vld     <= 1'b0;
                        length_error <= 1'b0;
                        nan_seen     <= 1'b0;
                    end
                end
                ARGMAX_COLLECT: begin
                    if (accept) begin
                        idx        <= idx + 1'b1;
                        best_index <= nxt_index;
                        best_vld   <= nxt_vld;
                        nan_seen   <= nan_seen | (is_nan & NAN_SKIP);
                        if (better) begin
                            best_key   <= key;
                            best_value <= logit_data;
                        end
                        if (final_beat) begin
                            state        <= ARGMAX_DONE;
                            token_valid  <= 1'b1;
                            token        <= nxt_index;
                            max_logit    <= nxt_vld ? nxt_value : FP16_QNAN;
                            length_error <= !(logit_last && (idx == LAST_IDX));
                        end
                    end
                end
                ARGMAX_DONE: begin
                    token_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ARGMAX_IDLE;
                end
                default: begin
                    state <= ARGMAX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logit_argmax.sv
// Randomised bench for logit_argmax: a numeric argmax model over the accepted
// logits is compared against the DUT every cycle, plus directed literal cases.
module tb_logit_argmax;
    import inference_pkg::*;

    localparam int VOCAB = 128;
    localparam int TW    = 7;
`ifdef ARGMAX_NAN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, logit_valid, logit_last;
    logic [15:0]   logit_data;
    logic          busy, token_valid, length_error, nan_seen;
    logic [TW-1:0] token;
    logic [15:0]   max_logit;

    int checks   = 0;
    int failures = 0;

    logit_argmax #(.VOCAB_SIZE(VOCAB), .TOKEN_W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .logit_valid  (logit_valid),
        .logit_data   (logit_data),
        .logit_last   (logit_last),
        .busy         (busy),
        .token_valid  (token_valid),
        .token        (token),
        .max_logit    (max_logit),
        .length_error (length_error),
        .nan_seen     (nan_seen)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic bit is_nan16(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    // Numeric value of an FP16; infinities and NaNs get ranks beyond any finite value.
    function automatic real rank16(input logic [15:0] x);
        int  e = int'(x[14:10]);
        int  m = int'(x[9:0]);
        real mag;
        if (e == 31)     mag = (m == 0) ? 1.0e9 : 1.0e10 + real'(m);
        else if (e == 0) mag = real'(m) * pow2(-24);
        else             mag = real'(1024 + m) * pow2(e - 25);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] int_to_fp16(input int n);
        int          e = 0;
        logic [15:0] r;
        if (n == 0) return 16'h0000;
        while ((n >> (e + 1)) != 0) e++;
        r[15]    = 1'b0;
        r[14:10] = 5'(e + 15);
        r[9:0]   = 10'((n << (10 - e)) & 'h3FF);
        return r;
    endfunction

    logic [15:0] model_q[$];

    function automatic void ref_result(output int tok, output logic [15:0] mx);
        bit  have = 1'b0;
        real best = 0.0;
        tok = 0;
        mx  = FP16_QNAN;
        foreach (model_q[i]) begin
            if (SKIP && is_nan16(model_q[i])) continue;
            if (!have || rank16(model_q[i]) > best) begin
                have = 1'b1;
                best = rank16(model_q[i]);
                tok  = i;
                mx   = model_q[i];
            end
        end
    endfunction

    bit            m_active = 0, m_done = 0;
    logic          exp_busy = 0, exp_tv = 0, exp_lerr = 0, exp_nan = 0;
    logic [TW-1:0] exp_token = '0;
    logic [15:0]   exp_max = 16'h0000;

    always @(posedge clk) begin
        int          t;
        logic [15:0] mx;
        if (reset) begin
            m_active = 0; m_done = 0; exp_busy = 0; exp_tv = 0;
            exp_lerr = 0; exp_nan = 0; exp_token = '0; exp_max = 16'h0000;
            model_q.delete();
        end else if (m_done) begin
            m_done = 0; exp_tv = 0; exp_busy = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; exp_busy = 1; exp_lerr = 0; exp_nan = 0;
                model_q.delete();
            end
        end else if (logit_valid) begin
            model_q.push_back(logit_data);
            if (SKIP && is_nan16(logit_data)) exp_nan = 1;
            if (logit_last || model_q.size() == VOCAB) begin
                ref_result(t, mx);
                exp_token = TW'(t);
                exp_max   = mx;
                exp_lerr  = !(logit_last && model_q.size() == VOCAB);
                exp_tv    = 1; m_active = 0; m_done = 1;
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 16'(busy), 16'(exp_busy));
            chk("token_valid", 16'(token_valid), 16'(exp_tv));
            chk("token", 16'(token), 16'(exp_token));
            chk("max_logit", max_logit, exp_max);
            chk("nan_seen", 16'(nan_seen), 16'(exp_nan));
            if (exp_tv) chk("length_error", 16'(length_error), 16'(exp_lerr));
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] stim [0:VOCAB-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; logit_valid = 0; logit_last = 0;
    endtask

    // Ends just after the edge that accepts the final beat.
    task automatic drive_pass(input int n, input int last_idx, input int gap_pct, input bit noise);
        if (noise) begin
            for (int k = 0; k < 3; k++) begin
                logit_valid = 1; logit_data = 16'($urandom); logit_last = 1'($urandom); step();
            end
        end
        logit_valid = 0; logit_last = 0; start = 1; step(); start = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
                logit_valid = 0; logit_data = 16'($urandom); logit_last = 1'($urandom);
                start = noise ? 1'($urandom) : 1'b0;
                step();
            end
            logit_valid = 1; logit_data = stim[i]; logit_last = (i == last_idx);
            start = noise ? 1'($urandom) : 1'b0;
            step();
            if (i == last_idx) break;
        end
        idle_inputs();
        if (noise) begin
            start = 1; logit_valid = 1; logit_last = 1; logit_data = 16'h7BFF;
        end
    endtask

    task automatic settle();
        step(); idle_inputs(); step();
    endtask

    task automatic fill_random(input int kind);
        logic [15:0] pool [5];
        pool = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00};
        for (int i = 0; i < VOCAB; i++) begin
            case (kind)
                0:       stim[i] = 16'($urandom);
                1:       stim[i] = pool[$urandom_range(4)];
                2:       stim[i] = 16'($urandom_range(16'h7BFF));
                default: stim[i] = 16'h8000 | 16'($urandom_range(16'h7BFF));
            endcase
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1; logit_data = 16'h0; idle_inputs();
        step(); cmp_en = 1; step(); step();
        @(negedge clk);
        chk("reset_token", 16'(token), 16'h0000);
        chk("reset_max", max_logit, 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0000);
        step(); reset = 0;

        // Model pins
        chk("model_fp16_127", int_to_fp16(127), 16'h57F0);
        checks++;
        if (rank16(16'h3C00) != 1.0) begin failures++; $display("FAIL model_rank_one: got %f expected 1.0", rank16(16'h3C00)); end

        // Descending ramp, gap-free then gapped with ignored inputs
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < VOCAB; i++) stim[i] = int_to_fp16(127 - i);
            drive_pass(VOCAB, VOCAB - 1, r * 40, r == 1);
            @(negedge clk);
            chk("ramp_latency", 16'(token_valid), 16'h0001);
            chk("ramp_token", 16'(token), 16'h0000);
            chk("ramp_max", max_logit, 16'h57F0);
            chk("ramp_lerr", 16'(length_error), 16'h0000);
            chk("model_ramp_token", 16'(exp_token), 16'h0000);
            settle();
        end

        // Negatives with signed zero tie
        for (int i = 0; i < VOCAB; i++) stim[i] = 16'hBC00;
        stim[90] = 16'h8000; stim[91] = 16'h0000;
        drive_pass(VOCAB, VOCAB - 1, 0, 0);
        @(negedge clk);
        chk("negz_token", 16'(token), 16'd90);
        chk("negz_max", max_logit, 16'h8000);
        settle();

        // Early last
        for (int i = 0; i < VOCAB; i++) stim[i] = 16'($urandom_range(16'h3FFF));
        stim[10] = 16'h4200;
        drive_pass(50, 49, 20, 0);
        @(negedge clk);
        chk("early_token", 16'(token), 16'd10);
        chk("early_max", max_logit, 16'h4200);
        chk("early_lerr", 16'(length_error), 16'h0001);
        settle();

        // Full count without last
        fill_random(2);
        drive_pass(VOCAB, -1, 0, 0);
        @(negedge clk);
        chk("nolast_lerr", 16'(length_error), 16'h0001);
        settle();

        // NaN handling
        for (int i = 0; i < VOCAB; i++) stim[i] = 16'h0000;
        stim[5] = 16'h7E00; stim[6] = 16'h3C00;
        drive_pass(VOCAB, VOCAB - 1, 0, 0);
        @(negedge clk);
        chk("nan_token", 16'(token), SKIP ? 16'd6 : 16'd5);
        chk("nan_seen_flag", 16'(nan_seen), SKIP ? 16'd1 : 16'd0);
        settle();

        // All NaN: negative quiet NaNs with one positive NaN
        for (int i = 0; i < VOCAB; i++) stim[i] = 16'hFE00;
        stim[3] = 16'h7D00;
        drive_pass(VOCAB, VOCAB - 1, 0, 0);
        @(negedge clk);
        chk("allnan_token", 16'(token), SKIP ? 16'd0 : 16'd3);
        chk("allnan_max", max_logit, SKIP ? 16'h7E00 : 16'h7D00);
        settle();

        // Reset mid-pass at index 60
        fill_random(2);
        logit_valid = 0; start = 1; step(); start = 0;
        for (int i = 0; i < 60; i++) begin
            logit_valid = 1; logit_data = stim[i]; logit_last = 0; step();
        end
        reset = 1; start = 1; logit_valid = 1; logit_data = stim[60]; step();
        reset = 0; idle_inputs();
        @(negedge clk);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_tv", 16'(token_valid), 16'h0000);
        chk("rst_token", 16'(token), 16'h0000);
        chk("rst_max", max_logit, 16'h0000);
        step(); step();
        for (int i = 0; i < VOCAB; i++) stim[i] = int_to_fp16(i);
        drive_pass(VOCAB, VOCAB - 1, 30, 1);
        @(negedge clk);
        chk("post_rst_token", 16'(token), 16'd127);
        chk("post_rst_max", max_logit, 16'h57F0);
        settle();

        // Randomised passes
        for (int p = 0; p < 14; p++) begin
            int mode, li;
            fill_random(int'($urandom_range(3)));
            mode = int'($urandom_range(2));
            li   = (mode == 0) ? VOCAB - 1 : (mode == 1) ? -1 : int'($urandom_range(VOCAB - 2));
            drive_pass(VOCAB, li, int'($urandom_range(50)), 1'($urandom));
            @(negedge clk);
            settle();
        end

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
